mreg_file_master: RTL and testbench
===================================

// Module: mreg_file_master
// PURPOSE
// Initiator for the micro register file's two-phase shared-write-bus protocol.
// - Accepts one read/write request at a time on a valid/ready port.
// - Sequences the cpu_state / reg_file_en / reg_file_rw / reg_dst / shared_write_bus
//   cycles that the register file expects.
// - For reads, captures reg_rd_data and returns it on a valid/ready response port.
// - Sits between debug/host logic and the micro register file.
// PARAMETERS
// DATA_WIDTH       16    shared bus / register data width
// REG_SPEC_WIDTH   4     register select width (addresses 0..2**REG_SPEC_WIDTH-1)
// STATE_W          3     cpu_state width
// ST_IDLE          3'd0  cpu_state code driven when no transaction is active
// ST_EXECUTE1      3'd2  cpu_state code for the select/write-data phase
// ST_EXECUTE2      3'd3  cpu_state code for the commit phase
// SEL_MAP          4'd1  reg_dst code: bus carries register select
// WR_DATA_MAP      4'd2  reg_dst code: bus carries write data
// RW_WRITE         1'b1  reg_file_rw / req_rw write encoding (read = ~RW_WRITE)
// PORTS
// sys_clk           in   1               clock, all logic rising-edge
// sys_reset         in   1               synchronous, active-high reset
// req_valid         in   1               request present
// req_ready         out  1               request accepted when valid&&ready
// req_rw            in   1               RW_WRITE=write, else read
// req_addr          in   REG_SPEC_WIDTH  target register
// req_wdata         in   DATA_WIDTH      write data (ignored on read)
// rsp_valid         out  1               transaction complete
// rsp_ready         in   1               response consumed when valid&&ready
// rsp_rdata         out  DATA_WIDTH      read data (0 after write)
// cpu_state         out  STATE_W         phase code to register file
// reg_file_en       out  1               register file enable
// reg_file_rw       out  1               register file read/write
// reg_dst           out  4               bus destination map
// shared_write_bus  out  DATA_WIDTH      shared write bus
// reg_rd_data       in   DATA_WIDTH      registered read data from register file
// BEHAVIOUR
// - FSM states: IDLE, SEL, WDATA, COMMIT, CAPT, RESP. Bus outputs are decoded from
//   the state register only (Moore).
// - IDLE: req_ready=1. On req_valid, latch rw/addr/wdata and go to SEL.
//   Ready is low in all other states; req_valid there is ignored.
// - SEL: cpu_state=ST_EXECUTE1, en=1, reg_dst=SEL_MAP,
//   bus={zero-extend, addr}. Next: WDATA if write, else COMMIT.
// - WDATA: cpu_state=ST_EXECUTE1, en=1, reg_dst=WR_DATA_MAP, bus=wdata. Next: COMMIT.
// - COMMIT: cpu_state=ST_EXECUTE2, en=1, rw=latched rw, reg_dst=0, bus=0.
//   Next: RESP if write, else CAPT.
// - CAPT: idle bus. At the clock edge, rsp_rdata <= reg_rd_data
//   (the register file updates it at the end of COMMIT). Next: RESP.
// - RESP: idle bus, rsp_valid=1. rsp_rdata holds stable until rsp_ready;
//   then go to IDLE. Write responses carry rsp_rdata=0.
// - Idle bus values: cpu_state=ST_IDLE, en=0, rw=~RW_WRITE, reg_dst=0, bus=0.
// - Latency from accept edge to rsp_valid: write 4 cycles (SEL,WDATA,COMMIT,RESP);
//   read 4 cycles (SEL,COMMIT,CAPT,RESP). Minimum 1 IDLE cycle between transactions.
// - Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0,
//   all latched fields 0, bus outputs at idle values.
// - Reset mid-transaction: return to IDLE on the next edge. No response is issued.
//   The write commit is not performed unless COMMIT has already completed.
// - Address wrap: none. req_addr is used as-is; the max address is legal.
// TESTING
// 1. Write addr 5, data 16'hBEEF.
//    -> Bus trace: (EXEC1,SEL,0x0005), (EXEC1,WRD,0xBEEF), (EXEC2,rw=1).
//    -> rsp_valid in the 4th cycle after accept; rsp_rdata=0.
// 2. Read addr 5 after test 1.
//    -> Bus trace: (EXEC1,SEL,0x0005), (EXEC2,rw=0), idle.
//    -> rsp_valid with rsp_rdata=16'hBEEF.
// 3. Read with rsp_ready held low 3 cycles.
//    -> rsp_valid and rsp_rdata stable, req_ready=0 throughout.
//    -> IDLE one cycle after rsp_ready.
// 4. req_valid held high with a new request while busy.
//    -> Not accepted until IDLE. Second request executes with its own values.
// 5. sys_reset asserted in COMMIT of a write to addr 3 (prior value 0x1111).
//    -> Next cycle: idle outputs, rsp_valid=0.
//    -> Subsequent read of addr 3 returns 0x1111.
// 6. Write 16'hFFFF to addr 15, then read addr 15.
//    -> Select bus=0x000F; read returns 16'hFFFF.

Source files
------------

// File: rtl/mreg_file_master.sv
// mreg_file_master
// Initiator for the micro register file's two-phase shared-write-bus protocol.
// A host issues one read or write at a time on a valid/ready request port. This
// block drives the register file's phase cycles. For a read, it returns the
// captured register data on a valid/ready response port.
//
// Ports
//   sys_clk, sys_reset          clock, synchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_rw/req_addr/req_wdata   request fields (req_rw == RW_WRITE means write)
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata                   read data (0 after a write)
//   cpu_state, reg_file_en,     phase outputs to the register file
//   reg_file_rw, reg_dst,
//   shared_write_bus
//   reg_rd_data                 registered read data from the register file
//
// state  | meaning
// IDLE   | ready for a request, bus idle
// SEL    | EXECUTE1, bus carries the register select
// WDATA  | EXECUTE1, bus carries the write data (writes only)
// COMMIT | EXECUTE2, register file performs the read or write
// CAPT   | bus idle, capture reg_rd_data (reads only)
// RESP   | response valid, wait for rsp_ready
module mreg_file_master #(
    parameter int                  DATA_WIDTH     = 16,
    parameter int                  REG_SPEC_WIDTH = 4,
    parameter int                  STATE_W        = 3,
    parameter logic [STATE_W-1:0]  ST_IDLE        = 3'd0,
    parameter logic [STATE_W-1:0]  ST_EXECUTE1    = 3'd2,
    parameter logic [STATE_W-1:0]  ST_EXECUTE2    = 3'd3,
    parameter logic [3:0]          SEL_MAP        = 4'd1,
    parameter logic [3:0]          WR_DATA_MAP    = 4'd2,
    parameter logic                RW_WRITE       = 1'b1
) (
    input  logic                      sys_clk,
    input  logic                      sys_reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_rw,
    input  logic [REG_SPEC_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [STATE_W-1:0]        cpu_state,
    output logic                      reg_file_en,
    output logic                      reg_file_rw,
    output logic [3:0]                reg_dst,
    output logic [DATA_WIDTH-1:0]     shared_write_bus,
    input  logic [DATA_WIDTH-1:0]     reg_rd_data
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEL    = 3'd1,
        S_WDATA  = 3'd2,
        S_COMMIT = 3'd3,
        S_CAPT   = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t                      state_q, state_d;
    logic                        rw_q, rw_d;
    logic [REG_SPEC_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q <= S_IDLE;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        rw_d             = rw_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        rdata_d          = rdata_q;
        req_ready        = 1'b0;
        rsp_valid        = 1'b0;
        cpu_state        = ST_IDLE;
        reg_file_en      = 1'b0;
        reg_file_rw      = ~RW_WRITE;
        reg_dst          = 4'd0;
        shared_write_bus = '0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    rw_d    = req_rw;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    // A write response must read back as zero.
                    rdata_d = '0;
                    state_d = S_SEL;
                end
            end
            S_SEL: begin
                cpu_state        = ST_EXECUTE1;
                reg_file_en      = 1'b1;
                reg_dst          = SEL_MAP;
                shared_write_bus = {{(DATA_WIDTH-REG_SPEC_WIDTH){1'b0}}, addr_q};
                state_d          = (rw_q == RW_WRITE) ? S_WDATA : S_COMMIT;
            end
            S_WDATA: begin
                cpu_state        = ST_EXECUTE1;
                reg_file_en      = 1'b1;
                reg_dst          = WR_DATA_MAP;
                shared_write_bus = wdata_q;
                state_d          = S_COMMIT;
            end
            S_COMMIT: begin
                cpu_state   = ST_EXECUTE2;
                reg_file_en = 1'b1;
                reg_file_rw = rw_q;
                state_d     = (rw_q == RW_WRITE) ? S_RESP : S_CAPT;
            end
            S_CAPT: begin
                // The register file updates reg_rd_data at the end of COMMIT.
                rdata_d = reg_rd_data;
                state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mreg_file_master.sv
module tb_mreg_file_master;

    localparam logic [2:0] EX_IDLE = 3'd0;
    localparam logic [2:0] EX1     = 3'd2;
    localparam logic [2:0] EX2     = 3'd3;
    localparam logic [3:0] SELM    = 4'd1;
    localparam logic [3:0] WRDM    = 4'd2;

    logic        sys_clk, sys_reset;
    logic        req_valid, req_ready, req_rw;
    logic [3:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_rdata;
    logic [2:0]  cpu_state;
    logic        reg_file_en, reg_file_rw;
    logic [3:0]  reg_dst;
    logic [15:0] shared_write_bus;
    logic [15:0] reg_rd_data;

    int checks = 0;
    int failures = 0;

    // Reference memory: what the host expects each register to contain.
    logic [15:0] ref_mem [16];

    // Next-request values driven while the DUT is busy (held-valid test).
    logic        nxt_rw;
    logic [3:0]  nxt_addr;
    logic [15:0] nxt_wdata;

    mreg_file_master dut (
        .sys_clk(sys_clk), .sys_reset(sys_reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .cpu_state(cpu_state), .reg_file_en(reg_file_en), .reg_file_rw(reg_file_rw),
        .reg_dst(reg_dst), .shared_write_bus(shared_write_bus), .reg_rd_data(reg_rd_data)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Behavioural micro register file: latches select and write data in
    // EXECUTE1, then commits or reads in EXECUTE2. It holds its contents across reset.
    logic [15:0] rf_mem [16] = '{default: 16'h0};
    logic [3:0]  rf_sel = 4'h0;
    logic [15:0] rf_wd = 16'h0;
    logic [15:0] rf_rd = 16'h0;
    always @(posedge sys_clk) begin
        if (cpu_state == EX1 && reg_file_en && reg_dst == SELM) rf_sel <= shared_write_bus[3:0];
        if (cpu_state == EX1 && reg_file_en && reg_dst == WRDM) rf_wd <= shared_write_bus;
        if (cpu_state == EX2 && reg_file_en && !sys_reset) begin
            if (reg_file_rw) rf_mem[rf_sel] <= rf_wd;
            else             rf_rd <= rf_mem[rf_sel];
        end
    end
    assign reg_rd_data = rf_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [2:0] cs, input logic en, input logic rw,
                                         input logic [3:0] dst, input logic [15:0] bus,
                                         input logic rv, input logic rr);
        return {5'b0, cs, en, rw, dst, bus, rv, rr};
    endfunction

    function automatic logic [31:0] obs();
        return pack(cpu_state, reg_file_en, reg_file_rw, reg_dst, shared_write_bus, rsp_valid, req_ready);
    endfunction

    // Expected observation in cycle cyc (1..4) after accept, from the phase rules.
    // The rw bit is left unchecked during EXECUTE1 phases.
    task automatic exp_trace(input logic rw, input logic [3:0] addr, input logic [15:0] wd,
                             input int cyc, output logic [31:0] e, output logic [31:0] m);
        logic [31:0] idle_rsp;
        m = 32'hFFFF_FFFF;
        idle_rsp = pack(EX_IDLE, 1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
        if (cyc == 1) begin
            e = pack(EX1, 1'b1, 1'b0, SELM, {12'd0, addr}, 1'b0, 1'b0);
            m[22] = 1'b0;
        end else if (rw) begin
            if (cyc == 2) begin
                e = pack(EX1, 1'b1, 1'b0, WRDM, wd, 1'b0, 1'b0);
                m[22] = 1'b0;
            end else if (cyc == 3) e = pack(EX2, 1'b1, 1'b1, 4'd0, 16'd0, 1'b0, 1'b0);
            else                   e = idle_rsp;
        end else begin
            if (cyc == 2)      e = pack(EX2, 1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
            else if (cyc == 3) e = pack(EX_IDLE, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
            else               e = idle_rsp;
        end
    endtask

    // Called at a negedge. Issues one request, checks the bus trace, latency,
    // response data and stability while rsp_ready is held low, then the return to IDLE.
    task automatic run_txn(input logic rw, input logic [3:0] addr, input logic [15:0] wd,
                           input int hold, input logic [15:0] exp_rd, input bit keep_valid);
        int n;
        int lat;
        logic [31:0] e, m;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge sys_clk);
        lat = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge sys_clk);
            if (cyc == 1) begin
                if (keep_valid) begin
                    req_rw = nxt_rw; req_addr = nxt_addr; req_wdata = nxt_wdata;
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (cyc <= 4) begin
                exp_trace(rw, addr, wd, cyc, e, m);
                chk($sformatf("trace_c%0d", cyc), obs() & m, e & m);
            end
            if (rsp_valid) begin
                lat = cyc;
                break;
            end
        end
        chk("latency", lat, 32'd4);
        if (lat == 0) return;
        chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, exp_rd});
        for (int i = 0; i < hold; i++) begin
            @(negedge sys_clk);
            chk("rsp_hold", {14'd0, rsp_valid, req_ready, rsp_rdata}, {14'd0, 1'b1, 1'b0, exp_rd});
        end
        rsp_ready = 1'b1;
        @(negedge sys_clk);
        rsp_ready = 1'b0;
        chk("back_to_idle", obs(), pack(EX_IDLE, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b1));
    endtask

    typedef struct {
        logic        rw;
        logic [3:0]  addr;
        logic [15:0] wdata;
        int          hold;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rw;
        logic [3:0]  a;
        logic [15:0] d;
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0;
        tbl[0] = '{1'b1, 4'd5,  16'hBEEF, 0, 16'h0000};
        tbl[1] = '{1'b0, 4'd5,  16'h0000, 0, 16'hBEEF};
        tbl[2] = '{1'b0, 4'd5,  16'h1234, 3, 16'hBEEF};
        tbl[3] = '{1'b1, 4'd15, 16'hFFFF, 1, 16'h0000};
        tbl[4] = '{1'b0, 4'd15, 16'h0000, 0, 16'hFFFF};
        tbl[5] = '{1'b1, 4'd0,  16'h0001, 2, 16'h0000};
        tbl[6] = '{1'b0, 4'd0,  16'h0000, 0, 16'h0001};

        sys_reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = 4'd0;
        req_wdata = 16'd0; rsp_ready = 1'b0;
        nxt_rw = 1'b0; nxt_addr = 4'd0; nxt_wdata = 16'd0;
        repeat (3) @(negedge sys_clk);
        sys_reset = 1'b0;
        chk("reset_outputs", obs(), pack(EX_IDLE, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b1));
        chk("reset_rdata", {16'd0, rsp_rdata}, 32'd0);

        // Directed table: writes, reads, back-pressure, max address.
        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].hold, tbl[i].exp_rd, 1'b0);
            if (tbl[i].rw) ref_mem[tbl[i].addr] = tbl[i].wdata;
        end

        // req_valid held high with a different request while busy.
        nxt_rw = 1'b0; nxt_addr = 4'd7; nxt_wdata = 16'h0F0F;
        run_txn(1'b1, 4'd7, 16'hA5A5, 1, 16'h0000, 1'b1);
        ref_mem[7] = 16'hA5A5;
        chk("held_valid_still_up", {31'd0, req_valid}, 32'd1);
        run_txn(1'b0, 4'd7, 16'h0F0F, 0, ref_mem[7], 1'b0);

        // Reset during COMMIT of a write: no response, no commit.
        run_txn(1'b1, 4'd3, 16'h1111, 0, 16'h0000, 1'b0);
        ref_mem[3] = 16'h1111;
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 4'd3; req_wdata = 16'h2222;
        @(posedge sys_clk);
        @(negedge sys_clk);
        req_valid = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("in_commit", {29'd0, cpu_state}, {29'd0, EX2});
        sys_reset = 1'b1;
        @(negedge sys_clk);
        sys_reset = 1'b0;
        chk("reset_mid_txn", obs(), pack(EX_IDLE, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b1));
        run_txn(1'b0, 4'd3, 16'h0000, 0, ref_mem[3], 1'b0);

        // Randomized traffic against the reference memory.
        for (int i = 0; i < 40; i++) begin
            rw = 1'($urandom_range(0, 1));
            a  = 4'($urandom_range(0, 15));
            d  = 16'($urandom);
            run_txn(rw, a, d, $urandom_range(0, 3), rw ? 16'h0000 : ref_mem[a], 1'b0);
            if (rw) ref_mem[a] = d;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
